pay_controller: RTL and testbench

PAY_CONTROLLER -- requirements
Module: pay_controller

---
 rtl/pay_controller_if.sv | 24 ++
 rtl/pay_controller.sv | 97 +++++++++
 tb/tb_pay_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pay_controller_if.sv
// pay_controller_if: payment request/coin/result signal bundle.
// master drives start/price/coin_valid/coin_val/cancel and observes the results;
// slave (the controller) drives enterpay/paid_total/change/done/refund/busy.
interface pay_controller_if;
  logic       start;
  logic [7:0] price;
  logic       coin_valid;
  logic [2:0] coin_val;
  logic       cancel;
  logic       enterpay;
  logic [7:0] paid_total;
  logic [7:0] change;
  logic       done;
  logic       refund;
  logic       busy;
  modport master (
    output start, price, coin_valid, coin_val, cancel,
    input  enterpay, paid_total, change, done, refund, busy
  );
  modport slave (
    input  start, price, coin_valid, coin_val, cancel,
    output enterpay, paid_total, change, done, refund, busy
  );
endinterface

// File: rtl/pay_controller.sv
// pay_controller: coin payment FSM with timeout, cancel, saturating total and change.
// Ports: clk, rst_n (async active-low), bus (pay_controller_if.slave): start/price
// request, coin_valid/coin_val strobe, cancel; registered enterpay, paid_total,
// change, done/refund pulses and busy.
module pay_controller #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  pay_controller_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, SETTLE, REFUND} state_t;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYC - 1);
  state_t      state_q, state_d;
  logic [7:0]  price_q, price_d;
  logic [7:0]  paid_q, paid_d;
  logic [7:0]  change_q, change_d;
  logic [15:0] timer_q, timer_d;
  logic        done_q, refund_q, enterpay_q, busy_q;
  logic [7:0]  coin_amt;
  logic [8:0]  sum;
  logic [7:0]  sum_sat;
  logic        coin_ok;
  assign coin_amt = bus.coin_val == 3'd1 ? 8'd1  :
                    bus.coin_val == 3'd2 ? 8'd2  :
                    bus.coin_val == 3'd3 ? 8'd5  :
                    bus.coin_val == 3'd4 ? 8'd10 :
                    bus.coin_val == 3'd5 ? 8'd20 :
                    bus.coin_val == 3'd6 ? 8'd50 :
                    bus.coin_val == 3'd7 ? 8'd100 : 8'd0;
  assign coin_ok = bus.coin_valid && bus.coin_val != 3'd0;
  assign sum     = {1'b0, paid_q} + {1'b0, coin_amt};
  assign sum_sat = sum[8] ? 8'hFF : sum[7:0];
  // change is computed on the edge entering SETTLE/REFUND so it is valid alongside the pulse
  always_comb begin
    state_d  = state_q;
    price_d  = price_q;
    paid_d   = paid_q;
    change_d = change_q;
    timer_d  = timer_q;
    unique case (state_q)
      IDLE: if (bus.start && bus.price != 8'd0) begin
        state_d  = COLLECT;
        price_d  = bus.price;
        paid_d   = 8'd0;
        change_d = 8'd0;
        timer_d  = 16'd0;
      end
      COLLECT: if (bus.cancel) begin
        state_d  = REFUND;
        change_d = paid_q;
      end else if (coin_ok) begin
        paid_d  = sum_sat;
        timer_d = 16'd0;
        if (sum_sat >= price_q) begin
          state_d  = SETTLE;
          change_d = sum_sat - price_q;
        end
      end else if (timer_q == T_LAST) begin
        state_d  = REFUND;
        change_d = paid_q;
      end else begin
        timer_d = timer_q + 16'd1;
      end
      SETTLE, REFUND: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      price_q    <= '0;
      paid_q     <= '0;
      change_q   <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      refund_q   <= 1'b0;
      enterpay_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      price_q    <= price_d;
      paid_q     <= paid_d;
      change_q   <= change_d;
      timer_q    <= timer_d;
      done_q     <= state_d == SETTLE;
      refund_q   <= state_d == REFUND;
      enterpay_q <= state_d == COLLECT;
      busy_q     <= state_d != IDLE;
    end
  end
  assign bus.enterpay   = enterpay_q;
  assign bus.paid_total = paid_q;
  assign bus.change     = change_q;
  assign bus.done       = done_q;
  assign bus.refund     = refund_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pay_controller.sv
// tb_pay_controller: directed self-checking bench for pay_controller (TIMEOUT_CYC=8).
module tb_pay_controller;
  logic clk = 1'b0;
  logic rst_n;
  int passed = 0;
  int total = 0;
  pay_controller_if bus();
  pay_controller #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic coin(input logic [2:0] c);
    bus.coin_valid = 1'b1;
    bus.coin_val   = c;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 3'd0;
  endtask
  task automatic pay_start(input logic [7:0] p);
    bus.start = 1'b1;
    bus.price = p;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.price = 8'd0;
    bus.coin_valid = 1'b0;
    bus.coin_val = 3'd0;
    bus.cancel = 1'b0;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_enterpay", bus.enterpay, 0);
    chk("rst_paid", bus.paid_total, 0);
    chk("rst_change", bus.change, 0);
    chk("rst_pulses", {bus.done, bus.refund}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    // price 15, coins 10 + 5
    pay_start(8'd15);
    chk("t1_enterpay", bus.enterpay, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_paid0", bus.paid_total, 0);
    coin(3'd4);
    chk("t1_paid10", bus.paid_total, 10);
    chk("t1_nodone", bus.done, 0);
    coin(3'd3);
    chk("t1_paid15", bus.paid_total, 15);
    chk("t1_done", bus.done, 1);
    chk("t1_change", bus.change, 0);
    chk("t1_enterpay_fall", bus.enterpay, 0);
    chk("t1_norefund", bus.refund, 0);
    tick();
    chk("t1_done_once", bus.done, 0);
    chk("t1_idle", bus.busy, 0);
    // price 12, coins 10 + 5 -> change 3
    pay_start(8'd12);
    chk("t2_paid_clear", bus.paid_total, 0);
    coin(3'd4);
    coin(3'd3);
    chk("t2_done", bus.done, 1);
    chk("t2_change", bus.change, 3);
    tick();
    tick();
    chk("t2_hold_paid", bus.paid_total, 15);
    chk("t2_hold_change", bus.change, 3);
    chk("t2_idle", bus.busy, 0);
    // price 30, coin 20, then cancel with coin 10
    pay_start(8'd30);
    chk("t3_change_clear", bus.change, 0);
    coin(3'd5);
    chk("t3_paid20", bus.paid_total, 20);
    bus.cancel = 1'b1;
    coin(3'd4);
    bus.cancel = 1'b0;
    chk("t3_refund", bus.refund, 1);
    chk("t3_nodone", bus.done, 0);
    chk("t3_change", bus.change, 20);
    chk("t3_paid", bus.paid_total, 20);
    tick();
    chk("t3_refund_once", bus.refund, 0);
    chk("t3_idle", bus.busy, 0);
    // timeout: price 5, coin 2, then silence -> refund 8 cycles after the coin
    pay_start(8'd5);
    coin(3'd2);
    for (int i = 0; i < 7; i++) tick();
    chk("t4_pre_timeout", bus.refund, 0);
    chk("t4_still_collect", bus.enterpay, 1);
    tick();
    chk("t4_refund", bus.refund, 1);
    chk("t4_change", bus.change, 2);
    tick();
    chk("t4_idle", bus.busy, 0);
    // coin on expiry cycle restarts timer; code 000 does not
    pay_start(8'd5);
    coin(3'd2);
    for (int i = 0; i < 7; i++) tick();
    coin(3'd1);
    chk("t5_no_refund", bus.refund, 0);
    chk("t5_paid3", bus.paid_total, 3);
    chk("t5_collect", bus.enterpay, 1);
    for (int i = 0; i < 3; i++) tick();
    coin(3'd0);
    chk("t5_zero_code", bus.paid_total, 3);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_pre_timeout", bus.refund, 0);
    tick();
    chk("t5_refund", bus.refund, 1);
    chk("t5_change", bus.change, 3);
    tick();
    // price 200: start ignored mid-collect, settles at 200, coin ignored in IDLE
    pay_start(8'd200);
    coin(3'd7);
    chk("t6_paid100", bus.paid_total, 100);
    pay_start(8'd5);
    chk("t6_start_ignored", bus.paid_total, 100);
    chk("t6_still_collect", bus.enterpay, 1);
    coin(3'd7);
    chk("t6_done", bus.done, 1);
    chk("t6_paid200", bus.paid_total, 200);
    chk("t6_change", bus.change, 0);
    tick();
    coin(3'd7);
    chk("t6_idle_coin", bus.paid_total, 200);
    chk("t6_idle", bus.busy, 0);
    // saturation: price 250, three 100 coins -> 255, change 5
    pay_start(8'd250);
    coin(3'd7);
    coin(3'd7);
    chk("t7_no_done", bus.done, 0);
    coin(3'd7);
    chk("t7_sat", bus.paid_total, 255);
    chk("t7_done", bus.done, 1);
    chk("t7_change", bus.change, 5);
    tick();
    // async reset mid-collect with paid 7
    pay_start(8'd50);
    coin(3'd3);
    coin(3'd2);
    chk("t8_paid7", bus.paid_total, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_async_paid", bus.paid_total, 0);
    chk("t8_async_enterpay", bus.enterpay, 0);
    chk("t8_async_busy", bus.busy, 0);
    tick();
    chk("t8_no_pulses", {bus.done, bus.refund}, 0);
    rst_n = 1'b1;
    pay_start(8'd0);
    chk("t8_zero_price", bus.busy, 0);
    pay_start(8'd9);
    chk("t8_restart", bus.enterpay, 1);
    chk("t8_restart_paid", bus.paid_total, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
